// File: rtl/izh_pkg.sv
// Shared types, Q-format constants and helpers for the Izhikevich neuron array.
// Constants are integer-derived so they fold at elaboration for any W/FRAC.
package izh_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StUpdate = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SelA = 2'd0,
    SelB = 2'd1,
    SelC = 2'd2,
    SelD = 2'd3
  } cfg_sel_e;

  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

  // round(0.04 * 2^frac)
  function automatic longint k04(input int unsigned frac);
    return ((longint'(4) <<< frac) + 50) / 100;
  endfunction

  function automatic longint k5();
    return 5;
  endfunction

  function automatic longint k140(input int unsigned frac);
    return longint'(140) <<< frac;
  endfunction

  function automatic longint thresh(input int unsigned frac);
    return longint'(30) <<< frac;
  endfunction

  // Regular-spiking defaults: a = 0.02, b = 0.2, c = -65, d = 8
  function automatic longint a_def(input int unsigned frac);
    return ((longint'(2) <<< frac) + 50) / 100;
  endfunction

  function automatic longint b_def(input int unsigned frac);
    return ((longint'(2) <<< frac) + 5) / 10;
  endfunction

  function automatic longint c_def(input int unsigned frac);
    return -(longint'(65) <<< frac);
  endfunction

  function automatic longint d_def(input int unsigned frac);
    return longint'(8) <<< frac;
  endfunction

  // Clamp x to the signed range of a w-bit value.
  function automatic longint sat(input longint x, input int unsigned w);
    longint hi;
    longint lo;
    longint r;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    r  = x;
    if (x > hi) begin
      r = hi;
    end else if (x < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/izh_update.sv
// Combinational single-neuron Euler step. All arithmetic is carried at 2W+4 bits
// and clamped back to W bits on the way out.
module izh_update
  import izh_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned FRAC     = 7,
  parameter int unsigned DT_SHIFT = 0
) (
  input  logic signed [W-1:0] v,
  input  logic signed [W-1:0] u,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  input  logic signed [W-1:0] cur,
  output logic signed [W-1:0] v_next,
  output logic signed [W-1:0] u_next,
  output logic                spike
);

  localparam int unsigned XW = 2 * W + 4;

  localparam logic signed [XW-1:0] K04    = XW'(k04(FRAC));
  localparam logic signed [XW-1:0] K5     = XW'(k5());
  localparam logic signed [XW-1:0] K140   = XW'(k140(FRAC));
  localparam logic signed [XW-1:0] Thresh = XW'(thresh(FRAC));

  function automatic logic signed [W-1:0] clamp(input logic signed [XW-1:0] x);
    longint t;
    t = sat(longint'(x), W);
    return t[W-1:0];
  endfunction

  logic signed [XW-1:0] vx, ux, ax, bx, dx, ix;
  logic signed [XW-1:0] sq, dv, du, v_sum, u_sum, u_spk;

  always_comb begin
    vx     = XW'(v);
    ux     = XW'(u);
    ax     = XW'(a);
    bx     = XW'(b);
    dx     = XW'(d);
    ix     = XW'(cur);
    sq     = (K04 * ((vx * vx) >>> FRAC)) >>> FRAC;
    dv     = sq + K5 * vx + K140 - ux + ix;
    v_sum  = vx + (dv >>> DT_SHIFT);
    du     = (ax * (((bx * vx) >>> FRAC) - ux)) >>> FRAC;
    u_sum  = ux + (du >>> DT_SHIFT);
    u_spk  = ux + dx;
    spike  = (vx >= Thresh);
    v_next = clamp(v_sum);
    u_next = clamp(u_sum);
    if (spike) begin
      v_next = c;
      u_next = clamp(u_spk);
    end
  end

endmodule

// File: rtl/izh_array.sv
// Time-multiplexed Izhikevich neuron array: one shared datapath walks every neuron
// once per step pulse, one neuron per clock, with run-time writable parameters.
module izh_array
  import izh_pkg::*;
#(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned W         = 16,
  parameter int unsigned FRAC      = 7,
  parameter int unsigned DT_SHIFT  = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              step,
  input  logic [N_NEURONS*W-1:0]            current_flat,
  input  logic                              cfg_we,
  input  logic [idx_w(N_NEURONS)-1:0]       cfg_addr,
  input  logic [1:0]                        cfg_sel,
  input  logic signed [W-1:0]               cfg_data,
  output logic                              busy,
  output logic                              done,
  output logic [N_NEURONS-1:0]              spike_vec,
  output logic signed [W-1:0]               v_out,
  output logic [idx_w(N_NEURONS)-1:0]       v_idx,
  output logic                              v_valid
);

  localparam int unsigned IW = idx_w(N_NEURONS);

  localparam logic signed [W-1:0] ADef = W'(a_def(FRAC));
  localparam logic signed [W-1:0] BDef = W'(b_def(FRAC));
  localparam logic signed [W-1:0] CDef = W'(c_def(FRAC));
  localparam logic signed [W-1:0] DDef = W'(d_def(FRAC));
  localparam logic [IW-1:0]       LastIdx = IW'(N_NEURONS - 1);

  state_e              state_q;
  logic [IW-1:0]       idx_q;
  logic signed [W-1:0] v_q [N_NEURONS];
  logic signed [W-1:0] u_q [N_NEURONS];
  logic signed [W-1:0] a_q [N_NEURONS];
  logic signed [W-1:0] b_q [N_NEURONS];
  logic signed [W-1:0] c_q [N_NEURONS];
  logic signed [W-1:0] d_q [N_NEURONS];

  logic signed [W-1:0] cur_sel;
  logic signed [W-1:0] v_next;
  logic signed [W-1:0] u_next;
  logic                spike;
  logic [31:0]         addr_ext;
  logic                cfg_ok;

  assign cur_sel  = current_flat[idx_q*W +: W];
  assign addr_ext = 32'(cfg_addr);
  // Guards non-power-of-two arrays where cfg_addr can name a missing neuron.
  assign cfg_ok   = cfg_we && (addr_ext < 32'(N_NEURONS));

  izh_update #(
    .W        (W),
    .FRAC     (FRAC),
    .DT_SHIFT (DT_SHIFT)
  ) u_update (
    .v      (v_q[idx_q]),
    .u      (u_q[idx_q]),
    .a      (a_q[idx_q]),
    .b      (b_q[idx_q]),
    .c      (c_q[idx_q]),
    .d      (d_q[idx_q]),
    .cur    (cur_sel),
    .v_next (v_next),
    .u_next (u_next),
    .spike  (spike)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spike_vec <= '0;
      v_out     <= '0;
      v_idx     <= '0;
      v_valid   <= 1'b0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= CDef;
        u_q[i] <= '0;
        a_q[i] <= ADef;
        b_q[i] <= BDef;
        c_q[i] <= CDef;
        d_q[i] <= DDef;
      end
    end else begin
      done    <= 1'b0;
      v_valid <= 1'b0;

      // Parameter writes land at this edge, so an update of the same neuron
      // in this cycle still sees the previous value.
      if (cfg_ok) begin
        unique case (cfg_sel_e'(cfg_sel))
          SelA: a_q[cfg_addr] <= cfg_data;
          SelB: b_q[cfg_addr] <= cfg_data;
          SelC: c_q[cfg_addr] <= cfg_data;
          SelD: d_q[cfg_addr] <= cfg_data;
          default: ;
        endcase
      end

      unique case (state_q)
        StIdle: begin
          if (step) begin
            state_q <= StUpdate;
            idx_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StUpdate: begin
          v_q[idx_q]       <= v_next;
          u_q[idx_q]       <= u_next;
          spike_vec[idx_q] <= spike;
          v_out            <= v_next;
          v_idx            <= idx_q;
          v_valid          <= 1'b1;
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_izh_array.sv
// Directed bench for izh_array: hand-computed key values plus a small
// fixed-point reference of the neuron equations for the remaining outputs.
module tb_izh_array;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned IW = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                step;
  logic [N*W-1:0]      current_flat;
  logic                cfg_we;
  logic [IW-1:0]       cfg_addr;
  logic [1:0]          cfg_sel;
  logic signed [W-1:0] cfg_data;
  logic                busy;
  logic                done;
  logic [N-1:0]        spike_vec;
  logic signed [W-1:0] v_out;
  logic [IW-1:0]       v_idx;
  logic                v_valid;

  logic signed [W-1:0] cur [N];

  longint mv [N];
  longint mu [N];
  longint ma [N];
  longint mb [N];
  longint mc [N];
  longint md [N];
  logic [N-1:0] mspk;
  longint got_v [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    current_flat = '0;
    for (int i = 0; i < N; i++) current_flat[i*W +: W] = cur[i];
  end

  izh_array #(
    .N_NEURONS (N),
    .W         (16),
    .FRAC      (7),
    .DT_SHIFT  (0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .step         (step),
    .current_flat (current_flat),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .busy         (busy),
    .done         (done),
    .spike_vec    (spike_vec),
    .v_out        (v_out),
    .v_idx        (v_idx),
    .v_valid      (v_valid)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat16(input longint x);
    longint r;
    r = x;
    if (x > 32767) r = 32767;
    if (x < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = -8320; mu[i] = 0;
      ma[i] = 3; mb[i] = 26; mc[i] = -8320; md[i] = 1024;
    end
    mspk = '0;
  endtask

  task automatic model_cfg(input int i, input int sel, input longint data);
    case (sel)
      0: ma[i] = data;
      1: mb[i] = data;
      2: mc[i] = data;
      default: md[i] = data;
    endcase
  endtask

  // Q9.7 neuron equations: K04 = 5, K5 = 5, K140 = 17920, THRESH = 3840, dt = 1.
  task automatic model_neuron(input int i, output longint vn, output bit sp);
    longint v, u, sq, dv, du;
    v = mv[i];
    u = mu[i];
    if (v >= 3840) begin
      vn    = mc[i];
      mu[i] = sat16(u + md[i]);
      sp    = 1'b1;
    end else begin
      sq    = (5 * ((v * v) >>> 7)) >>> 7;
      dv    = sq + 5 * v + 17920 - u + longint'(cur[i]);
      vn    = sat16(v + dv);
      du    = (ma[i] * (((mb[i] * v) >>> 7) - u)) >>> 7;
      mu[i] = sat16(u + du);
      sp    = 1'b0;
    end
    mv[i]   = vn;
    mspk[i] = sp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    step    = 1'b0;
    cfg_we  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input int i, input int sel, input longint data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = i[IW-1:0];
    cfg_sel  = sel[1:0];
    cfg_data = data[W-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(i, sel, data);
  endtask

  // One full pass; with hit set, a write to neuron 0 coincides with its update.
  task automatic run_pass(input string tag, input bit hit, input int sel, input longint data);
    longint vn;
    bit     sp;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check({tag, "_busy"}, busy, 1);
    if (hit) begin
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_sel  = sel[1:0];
      cfg_data = data[W-1:0];
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      model_neuron(i, vn, sp);
      if (hit && i == 0) model_cfg(0, sel, data);
      check({tag, "_valid"}, v_valid, 1);
      check({tag, "_idx"}, v_idx, i);
      check({tag, "_v"}, v_out, vn);
      got_v[i] = v_out;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_spikes"}, spike_vec, mspk);
    @(negedge clk);
    check({tag, "_done_off"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int p;
    int n_done;
    reset_n  = 1'b0;
    step     = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_sel  = '0;
    cfg_data = '0;
    for (int i = 0; i < N; i++) cur[i] = '0;

    // Reset values and a zero-current pass
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", v_valid, 0);
    check("rst_spikes", spike_vec, 0);
    check("rst_vout", v_out, 0);
    check("rst_vidx", v_idx, 0);
    run_pass("zero", 1'b0, 0, 0);
    for (int i = 0; i < N; i++) check("zero_v_hand", got_v[i], -10875);
    check("zero_spikes_hand", spike_vec, 0);

    // Strong drive on neuron 1: crosses threshold, then resets and bumps u
    do_reset();
    cur[1] = 16'sd32767;
    run_pass("drv1", 1'b0, 0, 0);
    check("drv1_v1_hand", got_v[1], 21892);
    check("drv1_spk_hand", spike_vec, 0);
    run_pass("drv2", 1'b0, 0, 0);
    check("drv2_v1_hand", got_v[1], -8320);
    check("drv2_spk_hand", spike_vec, 4'b0010);
    run_pass("drv3", 1'b0, 0, 0);
    check("drv3_v1_hand", got_v[1], 20908);

    // Custom reset potential on neuron 2, then saturation from just below threshold
    cur[1] = '0;
    cur[2] = 16'sd32767;
    cfg_write(2, 2, 32000);
    run_pass("c_a", 1'b0, 0, 0);
    run_pass("c_b", 1'b0, 0, 0);
    check("c_b_v2_hand", got_v[2], 32000);
    check("c_b_spk2_hand", spike_vec[2], 1);
    cfg_write(2, 2, 3000);
    run_pass("c_c", 1'b0, 0, 0);
    check("c_c_v2_hand", got_v[2], 3000);
    run_pass("c_d", 1'b0, 0, 0);
    check("c_d_sat_hand", got_v[2], 32767);

    // step held high: a new pass every N+1 cycles, mid-pass step ignored
    do_reset();
    for (int i = 0; i < N; i++) cur[i] = '0;
    @(negedge clk);
    step   = 1'b1;
    n_done = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      p = k % 5;
      check("held_done", done, (p == 0));
      check("held_busy", busy, (p != 0));
      if (p == 1) check("held_novalid", v_valid, 0);
      else check("held_idx", v_idx, (p + 3) % 5);
      if (done) n_done++;
    end
    step = 1'b0;
    @(negedge clk);
    check("held_ndone", n_done, 3);
    check("held_stop", busy, 0);

    // Write b of neuron 0 in the very cycle neuron 0 updates
    do_reset();
    run_pass("col1", 1'b1, 1, 100);
    run_pass("col2", 1'b0, 0, 0);
    check("col2_v0_hand", got_v[0], -11199);
    run_pass("col3", 1'b0, 0, 0);

    // Reset asserted mid-pass aborts it and restores every default
    do_reset();
    cur[3] = 16'sd1000;
    cfg_write(3, 0, 127);
    cfg_write(3, 1, 500);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", v_valid, 0);
    check("abort_spikes", spike_vec, 0);
    check("abort_vout", v_out, 0);
    reset_n = 1'b1;
    cur[3]  = '0;
    model_reset();
    n_done  = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_nodone", n_done, 0);
    run_pass("post1", 1'b0, 0, 0);
    for (int i = 0; i < N; i++) check("post1_v_hand", got_v[i], -10875);
    run_pass("post2", 1'b0, 0, 0);
    check("post2_v3_hand", got_v[3], -11199);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
